// File: rtl/cpu_pkg.sv
// Shared definitions for the writeback stage: datapath width, regsel codes
// and the control bundle captured in the EX->WB register.
package cpu_pkg;

  localparam int W = 32;

  localparam logic [1:0] REGSEL_ALU = 2'd0;
  localparam logic [1:0] REGSEL_HI  = 2'd1;
  localparam logic [1:0] REGSEL_LO  = 2'd2;

  typedef struct packed {
    logic       regwrite;
    logic [4:0] dest;
    logic [1:0] regsel;
    logic       gpio_in;
    logic       gpio_out;
  } wb_ctrl_t;

  // Destination register field: rt for I-type style writes, rd otherwise.
  function automatic logic [4:0] pick_dest(input logic rdrt, input logic [4:0] rt,
                                           input logic [4:0] rd);
    return rdrt ? rt : rd;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// EX/WB boundary bundle: EX-stage controls and data in, register-file write
// port, GPIO pins and forwarding selects out.
interface wb_stage_if #(parameter int W = cpu_pkg::W);

  logic         flush_EX;
  logic         regwrite_EX;
  logic [1:0]   regsel_EX;
  logic         enhilo_EX;
  logic         rdrt_EX;
  logic         GPIO_OUT;
  logic         GPIO_IN;
  logic [4:0]   rs_EX;
  logic [4:0]   rt_EX;
  logic [4:0]   rd_EX;
  logic [W-1:0] lo_EX;
  logic [W-1:0] hi_EX;
  logic [W-1:0] gpio_wdata_EX;
  logic [W-1:0] gpio_in;

  logic         regwrite_WB;
  logic [4:0]   writeaddr_WB;
  logic [W-1:0] writedata_WB;
  logic [W-1:0] gpio_out;
  logic         fwd_rs_EX;
  logic         fwd_rt_EX;

  // Upstream pipeline / pad side.
  modport master (
    output flush_EX, regwrite_EX, regsel_EX, enhilo_EX, rdrt_EX, GPIO_OUT, GPIO_IN,
    output rs_EX, rt_EX, rd_EX, lo_EX, hi_EX, gpio_wdata_EX, gpio_in,
    input  regwrite_WB, writeaddr_WB, writedata_WB, gpio_out, fwd_rs_EX, fwd_rt_EX
  );

  // Writeback stage side.
  modport slave (
    input  flush_EX, regwrite_EX, regsel_EX, enhilo_EX, rdrt_EX, GPIO_OUT, GPIO_IN,
    input  rs_EX, rt_EX, rd_EX, lo_EX, hi_EX, gpio_wdata_EX, gpio_in,
    output regwrite_WB, writeaddr_WB, writedata_WB, gpio_out, fwd_rs_EX, fwd_rt_EX
  );

endinterface

// File: rtl/wb_stage_hilo_reg.sv
// HI/LO multiply result pair. Loads both halves together; holds otherwise.
module hilo_reg #(parameter int W = cpu_pkg::W) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] hi_d,
  input  logic [W-1:0] lo_d,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  // HI/LO update on a live mult/multu, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (load) begin
      hi <= hi_d;
      lo <= lo_d;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: EX->WB pipeline register, HI/LO ownership, GPIO output
// register, write-data select and WB->EX forwarding selects.
// Optional macro GPIO_IN_SYNC_EN: route gpio_in through a two-flop
// synchronizer before the WB capture (3 cycles pin-to-WB instead of 1).
module wb_stage
  import cpu_pkg::*;
#(parameter int W = cpu_pkg::W) (
  input  logic   clk,
  input  logic   rst,
  wb_stage_if.slave bus
);

  logic         live_regwrite;
  logic         live_enhilo;
  logic         live_gpio_out;
  wb_ctrl_t     ctrl_d;
  wb_ctrl_t     ctrl_q;
  logic [W-1:0] lo_q;
  logic [W-1:0] gpio_wdata_q;
  logic [W-1:0] gpio_in_q;
  logic [W-1:0] gpio_sample;
  logic [W-1:0] gpio_out_q;
  logic [W-1:0] hi_reg;
  logic [W-1:0] lo_reg;
  logic [W-1:0] writedata;
  logic         regwrite_wb;

  // A bubble in EX must not write anything architecturally visible.
  always_comb begin
    live_regwrite   = bus.regwrite_EX & ~bus.flush_EX;
    live_enhilo     = bus.enhilo_EX   & ~bus.flush_EX;
    live_gpio_out   = bus.GPIO_OUT    & ~bus.flush_EX;
    ctrl_d.regwrite = live_regwrite;
    ctrl_d.dest     = pick_dest(bus.rdrt_EX, bus.rt_EX, bus.rd_EX);
    ctrl_d.regsel   = bus.regsel_EX;
    ctrl_d.gpio_in  = bus.GPIO_IN;
    ctrl_d.gpio_out = live_gpio_out;
  end

`ifdef GPIO_IN_SYNC_EN
  logic [W-1:0] gpio_meta;
  logic [W-1:0] gpio_sync;

  // Two-flop synchronizer for the asynchronous input pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_meta <= '0;
      gpio_sync <= '0;
    end else begin
      gpio_meta <= bus.gpio_in;
      gpio_sync <= gpio_meta;
    end
  end

  assign gpio_sample = gpio_sync;
`else
  assign gpio_sample = bus.gpio_in;
`endif

  // EX->WB pipeline register; reset discards the in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= '0;
      lo_q         <= '0;
      gpio_wdata_q <= '0;
      gpio_in_q    <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      lo_q         <= bus.lo_EX;
      gpio_wdata_q <= bus.gpio_wdata_EX;
      gpio_in_q    <= gpio_sample;
    end
  end

  // GPIO output register, written by a live GPIO_OUT instruction in EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out_q <= '0;
    end else if (live_gpio_out) begin
      gpio_out_q <= bus.gpio_wdata_EX;
    end
  end

  hilo_reg #(.W(W)) u_hilo (
    .clk  (clk),
    .rst  (rst),
    .load (live_enhilo),
    .hi_d (bus.hi_EX),
    .lo_d (bus.lo_EX),
    .hi   (hi_reg),
    .lo   (lo_reg)
  );

  // Write-data select. HI/LO are read live, so a mult in EX alongside an
  // mfhi/mflo in WB yields the pre-update value.
  always_comb begin
    writedata = lo_q;
    if (ctrl_q.gpio_out) begin
      writedata = gpio_wdata_q;
    end else if (ctrl_q.gpio_in) begin
      writedata = gpio_in_q;
    end else if (ctrl_q.regsel == REGSEL_HI) begin
      writedata = hi_reg;
    end else if (ctrl_q.regsel == REGSEL_LO) begin
      writedata = lo_reg;
    end
  end

  // $0 is hardwired, so it never gets a write and never forwards.
  always_comb begin
    regwrite_wb   = ctrl_q.regwrite & (ctrl_q.dest != 5'd0);
    bus.fwd_rs_EX = regwrite_wb & (ctrl_q.dest == bus.rs_EX);
    bus.fwd_rt_EX = regwrite_wb & (ctrl_q.dest == bus.rt_EX);
  end

  assign bus.regwrite_WB  = regwrite_wb;
  assign bus.writeaddr_WB = ctrl_q.dest;
  assign bus.writedata_WB = writedata;
  assign bus.gpio_out     = gpio_out_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage against a behavioural model of the
// writeback rules (honours GPIO_IN_SYNC_EN when defined).
module tb_wb_stage;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  wb_stage_if bus ();

  wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of architectural state as seen in the WB cycle.
  logic        m_rw;
  logic [4:0]  m_dest;
  int          m_sel;      // 0 = m_val, 1 = HI, 2 = LO
  logic [31:0] m_val;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_gpo;
  logic [31:0] pin_hist [0:1];

  function automatic logic [31:0] exp_data();
    if (m_sel == 1) return m_hi;
    if (m_sel == 2) return m_lo;
    return m_val;
  endfunction

  // One clock edge: update the model from the EX-stage inputs, then step off the edge.
  task automatic tick();
    logic [4:0]  d;
    logic [31:0] pins;
    logic        rw, hl, go;
    @(posedge clk);
    if (rst) begin
      m_rw = 0; m_dest = 0; m_sel = 0; m_val = 0;
      m_hi = 0; m_lo = 0; m_gpo = 0;
      pin_hist[0] = 0; pin_hist[1] = 0;
    end else begin
      rw = bus.regwrite_EX && !bus.flush_EX;
      hl = bus.enhilo_EX && !bus.flush_EX;
      go = bus.GPIO_OUT && !bus.flush_EX;
      d  = bus.rdrt_EX ? bus.rt_EX : bus.rd_EX;
`ifdef GPIO_IN_SYNC_EN
      pins = pin_hist[1];
      pin_hist[1] = pin_hist[0];
      pin_hist[0] = bus.gpio_in;
`else
      pins = bus.gpio_in;
`endif
      m_rw   = rw && (d != 5'd0);
      m_dest = d;
      m_sel  = 0;
      if (go) m_val = bus.gpio_wdata_EX;
      else if (bus.GPIO_IN) m_val = pins;
      else if (bus.regsel_EX == 2'd1) m_sel = 1;
      else if (bus.regsel_EX == 2'd2) m_sel = 2;
      else m_val = bus.lo_EX;
      if (hl) begin m_hi = bus.hi_EX; m_lo = bus.lo_EX; end
      if (go) m_gpo = bus.gpio_wdata_EX;
    end
    #1;
  endtask

  task automatic set_nop();
    bus.flush_EX = 0; bus.regwrite_EX = 0; bus.regsel_EX = 0; bus.enhilo_EX = 0;
    bus.rdrt_EX = 0; bus.GPIO_OUT = 0; bus.GPIO_IN = 0;
    bus.rs_EX = 5'($urandom); bus.rt_EX = 5'($urandom); bus.rd_EX = 5'($urandom);
    bus.lo_EX = $urandom; bus.hi_EX = $urandom; bus.gpio_wdata_EX = $urandom;
  endtask

  task automatic rand_ex();
    bus.flush_EX = ($urandom_range(0, 3) == 0);
    bus.regwrite_EX = 1'($urandom); bus.regsel_EX = 2'($urandom);
    bus.enhilo_EX = ($urandom_range(0, 3) == 0); bus.rdrt_EX = 1'($urandom);
    bus.GPIO_OUT = ($urandom_range(0, 5) == 0); bus.GPIO_IN = ($urandom_range(0, 5) == 0);
    bus.rs_EX = 5'($urandom_range(0, 7)); bus.rt_EX = 5'($urandom_range(0, 7));
    bus.rd_EX = 5'($urandom_range(0, 7));
    bus.lo_EX = $urandom; bus.hi_EX = $urandom; bus.gpio_wdata_EX = $urandom;
    if ($urandom_range(0, 2) == 0) bus.gpio_in = $urandom;
  endtask

  task automatic test_reset();
    rst = 1;
    rand_ex();
    bus.gpio_in = $urandom;
    tick(); rand_ex(); tick(); rand_ex(); #1;
    compared++; if (bus.regwrite_WB !== 1'b0) begin mismatched++;
      $display("FAIL reset_rw: got %0h want 0", bus.regwrite_WB); end
    compared++; if (bus.writeaddr_WB !== 5'd0) begin mismatched++;
      $display("FAIL reset_addr: got %0h want 0", bus.writeaddr_WB); end
    compared++; if (bus.writedata_WB !== 32'd0) begin mismatched++;
      $display("FAIL reset_data: got %0h want 0", bus.writedata_WB); end
    compared++; if (bus.gpio_out !== 32'd0) begin mismatched++;
      $display("FAIL reset_gpio_out: got %0h want 0", bus.gpio_out); end
    compared++; if (bus.fwd_rs_EX !== 1'b0 || bus.fwd_rt_EX !== 1'b0) begin mismatched++;
      $display("FAIL reset_fwd: got %0b%0b want 00", bus.fwd_rs_EX, bus.fwd_rt_EX); end
    rst = 0;
    set_nop(); bus.regwrite_EX = 1; bus.rd_EX = 9; bus.regsel_EX = 2'd1;
    tick(); set_nop(); bus.regwrite_EX = 1; bus.rd_EX = 9; bus.regsel_EX = 2'd2; #1;
    compared++; if (bus.writedata_WB !== 32'd0 || bus.writeaddr_WB !== 5'd9) begin mismatched++;
      $display("FAIL reset_mfhi: got %0h@%0d want 0@9", bus.writedata_WB, bus.writeaddr_WB); end
    tick(); set_nop(); #1;
    compared++; if (bus.writedata_WB !== 32'd0) begin mismatched++;
      $display("FAIL reset_mflo: got %0h want 0", bus.writedata_WB); end
  endtask

  task automatic test_mult_mf();
    set_nop(); bus.enhilo_EX = 1; bus.hi_EX = 32'h1; bus.lo_EX = 32'h2;
    tick(); set_nop(); bus.regwrite_EX = 1; bus.rd_EX = 8; bus.regsel_EX = 2'd1;
    tick(); set_nop(); bus.regwrite_EX = 1; bus.rd_EX = 8; bus.regsel_EX = 2'd2; #1;
    compared++; if (bus.regwrite_WB !== 1'b1 || bus.writeaddr_WB !== 5'd8 || bus.writedata_WB !== 32'h1)
      begin mismatched++; $display("FAIL mfhi: got %0b %0d %0h want 1 8 1",
        bus.regwrite_WB, bus.writeaddr_WB, bus.writedata_WB); end
    tick(); set_nop(); #1;
    compared++; if (bus.writedata_WB !== 32'h2) begin mismatched++;
      $display("FAIL mflo: got %0h want 2", bus.writedata_WB); end
    // mfhi in WB while a new mult sits in EX: WB sees the old HI
    bus.regwrite_EX = 1; bus.rd_EX = 10; bus.regsel_EX = 2'd1;
    tick(); set_nop(); bus.enhilo_EX = 1; bus.hi_EX = 32'h55; bus.lo_EX = 32'h66; #1;
    compared++; if (bus.writedata_WB !== 32'h1) begin mismatched++;
      $display("FAIL mult_vs_mfhi: got %0h want 1", bus.writedata_WB); end
    tick(); set_nop(); bus.regwrite_EX = 1; bus.rd_EX = 10; bus.regsel_EX = 2'd1;
    tick(); set_nop(); #1;
    compared++; if (bus.writedata_WB !== 32'h55) begin mismatched++;
      $display("FAIL mfhi_after_mult: got %0h want 55", bus.writedata_WB); end
  endtask

  task automatic test_add_fwd();
    set_nop(); bus.regwrite_EX = 1; bus.rd_EX = 5; bus.lo_EX = 32'h1234;
    tick(); set_nop(); bus.rs_EX = 5; bus.rt_EX = 7; #1;
    compared++; if (bus.regwrite_WB !== 1'b1 || bus.writeaddr_WB !== 5'd5 || bus.writedata_WB !== 32'h1234)
      begin mismatched++; $display("FAIL add: got %0b %0d %0h want 1 5 1234",
        bus.regwrite_WB, bus.writeaddr_WB, bus.writedata_WB); end
    compared++; if (bus.fwd_rs_EX !== 1'b1 || bus.fwd_rt_EX !== 1'b0) begin mismatched++;
      $display("FAIL add_fwd: got %0b%0b want 10", bus.fwd_rs_EX, bus.fwd_rt_EX); end
    bus.rs_EX = 3; bus.rt_EX = 5; #1;
    compared++; if (bus.fwd_rs_EX !== 1'b0 || bus.fwd_rt_EX !== 1'b1) begin mismatched++;
      $display("FAIL add_fwd_rt: got %0b%0b want 01", bus.fwd_rs_EX, bus.fwd_rt_EX); end
  endtask

  task automatic test_zero_dest();
    set_nop(); bus.regwrite_EX = 1; bus.rdrt_EX = 1; bus.rt_EX = 0; bus.lo_EX = 32'hFFFFFFFF;
    tick(); set_nop(); bus.rs_EX = 0; bus.rt_EX = 0; #1;
    compared++; if (bus.regwrite_WB !== 1'b0) begin mismatched++;
      $display("FAIL zero_rw: got %0b want 0", bus.regwrite_WB); end
    compared++; if (bus.fwd_rs_EX !== 1'b0 || bus.fwd_rt_EX !== 1'b0) begin mismatched++;
      $display("FAIL zero_fwd: got %0b%0b want 00", bus.fwd_rs_EX, bus.fwd_rt_EX); end
  endtask

  task automatic test_gpio();
    set_nop(); bus.GPIO_OUT = 1; bus.gpio_wdata_EX = 32'hA5;
    tick(); set_nop(); #1;
    compared++; if (bus.gpio_out !== 32'hA5) begin mismatched++;
      $display("FAIL gpio_out: got %0h want a5", bus.gpio_out); end
    bus.flush_EX = 1; bus.GPIO_OUT = 1; bus.gpio_wdata_EX = 32'hFF;
    tick(); set_nop(); #1;
    compared++; if (bus.gpio_out !== 32'hA5) begin mismatched++;
      $display("FAIL gpio_out_flush: got %0h want a5", bus.gpio_out); end
    // immediate read after a pin change: latency depends on synchronizer build
    bus.gpio_in = 32'h3C; bus.GPIO_IN = 1; bus.regwrite_EX = 1; bus.rd_EX = 3;
    tick(); set_nop(); #1;
    compared++; if (bus.writedata_WB !== exp_data()) begin mismatched++;
      $display("FAIL gpio_in_early: got %0h want %0h", bus.writedata_WB, exp_data()); end
    tick(); set_nop(); bus.GPIO_IN = 1; bus.regwrite_EX = 1; bus.rd_EX = 3;
    tick(); set_nop(); #1;
    compared++; if (bus.writedata_WB !== 32'h3C || bus.writeaddr_WB !== 5'd3) begin mismatched++;
      $display("FAIL gpio_in: got %0h@%0d want 3c@3", bus.writedata_WB, bus.writeaddr_WB); end
  endtask

  task automatic test_flush();
    logic [31:0] prior_hi;
    prior_hi = m_hi;
    set_nop(); bus.flush_EX = 1; bus.enhilo_EX = 1; bus.hi_EX = 32'hDEAD;
    bus.regwrite_EX = 1; bus.rd_EX = 4;
    tick(); set_nop(); bus.regwrite_EX = 1; bus.rd_EX = 8; bus.regsel_EX = 2'd1; #1;
    compared++; if (bus.regwrite_WB !== 1'b0) begin mismatched++;
      $display("FAIL flush_rw: got %0b want 0", bus.regwrite_WB); end
    tick(); set_nop(); #1;
    compared++; if (bus.writedata_WB !== prior_hi) begin mismatched++;
      $display("FAIL flush_hi: got %0h want %0h", bus.writedata_WB, prior_hi); end
  endtask

  task automatic test_reset_midstream();
    set_nop(); bus.regwrite_EX = 1; bus.rd_EX = 6; bus.lo_EX = 32'h77;
    tick(); set_nop(); bus.regwrite_EX = 1; bus.rd_EX = 7; rst = 1;
    tick(); set_nop(); bus.regwrite_EX = 1; bus.rd_EX = 7; rst = 0; #1;
    compared++; if (bus.regwrite_WB !== 1'b0 || bus.writedata_WB !== 32'd0) begin mismatched++;
      $display("FAIL mid_reset: got %0b %0h want 0 0", bus.regwrite_WB, bus.writedata_WB); end
    tick(); set_nop(); #1;
    compared++; if (bus.regwrite_WB !== 1'b1 || bus.writeaddr_WB !== 5'd7) begin mismatched++;
      $display("FAIL after_reset: got %0b %0d want 1 7", bus.regwrite_WB, bus.writeaddr_WB); end
  endtask

  task automatic test_random();
    logic er, ef;
    for (int i = 0; i < 300; i++) begin
      rand_ex();
      tick();
      bus.rs_EX = 5'($urandom_range(0, 7)); bus.rt_EX = 5'($urandom_range(0, 7)); #1;
      er = m_rw && (m_dest == bus.rs_EX);
      ef = m_rw && (m_dest == bus.rt_EX);
      compared++; if (bus.regwrite_WB !== m_rw) begin mismatched++;
        $display("FAIL rnd_rw[%0d]: got %0b want %0b", i, bus.regwrite_WB, m_rw); end
      compared++; if (bus.writeaddr_WB !== m_dest) begin mismatched++;
        $display("FAIL rnd_addr[%0d]: got %0d want %0d", i, bus.writeaddr_WB, m_dest); end
      compared++; if (bus.writedata_WB !== exp_data()) begin mismatched++;
        $display("FAIL rnd_data[%0d]: got %0h want %0h", i, bus.writedata_WB, exp_data()); end
      compared++; if (bus.gpio_out !== m_gpo) begin mismatched++;
        $display("FAIL rnd_gpio_out[%0d]: got %0h want %0h", i, bus.gpio_out, m_gpo); end
      compared++; if (bus.fwd_rs_EX !== er || bus.fwd_rt_EX !== ef) begin mismatched++;
        $display("FAIL rnd_fwd[%0d]: got %0b%0b want %0b%0b", i, bus.fwd_rs_EX, bus.fwd_rt_EX, er, ef); end
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1;
    set_nop();
    bus.gpio_in = 0;
    test_reset();
    test_mult_mf();
    test_add_fwd();
    test_zero_dest();
    test_gpio();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
